// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS-subset controller
// Holds state encodings, instruction classes, opcode/funct constants and the
// datapath select encodings used by mc_ctrl_decode and mc_ctrl_fsm.
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_e;
  typedef enum logic [3:0] {
    CLS_R, CLS_JR, CLS_ORI, CLS_LUI, CLS_ADDI, CLS_LOAD, CLS_STORE,
    CLS_BEQ, CLS_J, CLS_JAL, CLS_ILL
  } cls_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;
  localparam logic [2:0] REG_WRITE_SRC_ALU  = 3'd0;
  localparam logic [2:0] REG_WRITE_SRC_MEM  = 3'd1;
  localparam logic [2:0] REG_WRITE_SRC_ZERO = 3'd2;
  localparam logic [2:0] REG_WRITE_SRC_ONE  = 3'd3;
  localparam logic [2:0] REG_WRITE_SRC_PC   = 3'd4;
  localparam logic [2:0] REG_WRITE_SRC_SRA  = 3'd5;
  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;
  localparam logic [1:0] REG_WRITE_ADDR_RD  = 2'd0;
  localparam logic [1:0] REG_WRITE_ADDR_RT  = 2'd1;
  localparam logic [1:0] REG_WRITE_ADDR_R30 = 2'd2;
  localparam logic [1:0] REG_WRITE_ADDR_R31 = 2'd3;
  localparam logic ALU_SRC_REG = 1'b0;
  localparam logic ALU_SRC_IMM = 1'b1;
  localparam logic MEM_OP_WORD = 1'b0;
  localparam logic MEM_OP_BYTE = 1'b1;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational opcode/funct -> instruction class and per-class fields
// Ports: opcode_i/funct_i from IR; cls_o class; alu_ctl_o, ext_op_o, mem_op_o
// per-class datapath fields; sra_o selects the shifter write-back for sra.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output cls_e       cls_o,
  output logic [1:0] alu_ctl_o,
  output logic       ext_op_o,
  output logic       mem_op_o,
  output logic       sra_o
);
  always_comb begin
    cls_o = CLS_ILL;
    alu_ctl_o = ALU_ADD;
    ext_op_o = EXT_ZERO;
    mem_op_o = MEM_OP_WORD;
    sra_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: case (funct_i)
        FN_ADDU: cls_o = CLS_R;
        FN_SUBU: begin cls_o = CLS_R; alu_ctl_o = ALU_SUB; end
        FN_SLT:  begin cls_o = CLS_R; alu_ctl_o = ALU_SLT; end
        FN_SRA:  begin cls_o = CLS_R; sra_o = 1'b1; end
        FN_JR:   cls_o = CLS_JR;
        default: ;
      endcase
      OP_ORI:  begin cls_o = CLS_ORI; alu_ctl_o = ALU_OR; end
      OP_LUI:  cls_o = CLS_LUI;
      OP_ADDI: begin cls_o = CLS_ADDI; ext_op_o = EXT_SIGN; end
      OP_LW:   cls_o = CLS_LOAD;
      OP_LB:   begin cls_o = CLS_LOAD; mem_op_o = MEM_OP_BYTE; end
      OP_SW:   cls_o = CLS_STORE;
      OP_SB:   begin cls_o = CLS_STORE; mem_op_o = MEM_OP_BYTE; end
      OP_BEQ:  cls_o = CLS_BEQ;
      OP_J:    cls_o = CLS_J;
      OP_JAL:  cls_o = CLS_JAL;
      default: ;
    endcase
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle main controller sequencing FETCH/DECODE/EXEC/MEM/WB
// Ports: clk, rst (async, active-high); opcode_i/funct_i from IR; ALU flags
// zero_i/overflow_i (positive_i/signed_less_i reserved); datapath strobes
// *_o; illegal_o pulses in DECODE on undecoded instructions; state_dbg_o.
// MC_CTRL_PERF_CNT_EN: when defined, instr_retired_o counts retired legal
// instructions; otherwise it is tied to 0.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic        zero_i,
  input  logic        overflow_i,
  input  logic        positive_i,
  input  logic        signed_less_i,
  output logic [1:0]  alu_ctl_o,
  output logic        ext_op_o,
  output logic [2:0]  reg_src_o,
  output logic [1:0]  npc_sel_o,
  output logic        mem_write_o,
  output logic        mem_op_o,
  output logic        reg_write_o,
  output logic        alu_src_o,
  output logic [1:0]  reg_dst_o,
  output logic        rgs_ins_write_o,
  output logic        pc_write_o,
  output logic        illegal_o,
  output logic [3:0]  state_dbg_o,
  output logic [31:0] instr_retired_o
);
  state_e state_q, state_d;
  cls_e cls;
  logic [1:0] dec_alu;
  logic dec_ext, dec_mem, dec_sra;
  logic pc_we, ir_we, reg_we, mem_we;
  logic unused_flags;
  assign unused_flags = positive_i ^ signed_less_i;
  mc_ctrl_decode u_dec (
    .opcode_i (opcode_i),
    .funct_i  (funct_i),
    .cls_o    (cls),
    .alu_ctl_o(dec_alu),
    .ext_op_o (dec_ext),
    .mem_op_o (dec_mem),
    .sra_o    (dec_sra)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d = S_FETCH;
    alu_ctl_o = ALU_ADD;
    ext_op_o = EXT_ZERO;
    reg_src_o = REG_WRITE_SRC_ALU;
    npc_sel_o = NPC_PC4;
    mem_op_o = MEM_OP_WORD;
    alu_src_o = ALU_SRC_REG;
    reg_dst_o = REG_WRITE_ADDR_RD;
    illegal_o = 1'b0;
    pc_we = 1'b0;
    ir_we = 1'b0;
    reg_we = 1'b0;
    mem_we = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: case (cls)
        CLS_R: state_d = S_EXEC_R;
        CLS_ORI, CLS_LUI, CLS_ADDI: state_d = S_EXEC_I;
        CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
        CLS_BEQ: state_d = S_BRANCH;
        CLS_J, CLS_JAL, CLS_JR: state_d = S_JUMP;
        default: illegal_o = 1'b1;
      endcase
      // ALU inputs stay driven through ALU_WB so the result and overflow are stable at write-back
      S_EXEC_R, S_EXEC_I, S_ALU_WB: begin
        alu_src_o = cls == CLS_R ? ALU_SRC_REG : ALU_SRC_IMM;
        alu_ctl_o = dec_alu;
        ext_op_o = dec_ext;
        state_d = state_q == S_ALU_WB ? S_FETCH : S_ALU_WB;
        if (state_q == S_ALU_WB) begin
          reg_we = 1'b1;
          reg_dst_o = cls == CLS_R ? REG_WRITE_ADDR_RD
                    : (cls == CLS_ADDI && overflow_i) ? REG_WRITE_ADDR_R30 : REG_WRITE_ADDR_RT;
          reg_src_o = (cls == CLS_R && dec_sra) ? REG_WRITE_SRC_SRA
                    : (cls == CLS_ADDI && overflow_i) ? REG_WRITE_SRC_ONE : REG_WRITE_SRC_ALU;
        end
      end
      S_MEM_ADDR: begin
        alu_src_o = ALU_SRC_IMM;
        ext_op_o = EXT_SIGN;
        state_d = cls == CLS_LOAD ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_op_o = dec_mem;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_op_o = dec_mem;
        reg_we = 1'b1;
        reg_dst_o = REG_WRITE_ADDR_RT;
        reg_src_o = REG_WRITE_SRC_MEM;
      end
      S_MEM_WR: begin
        mem_op_o = dec_mem;
        mem_we = 1'b1;
      end
      S_BRANCH: begin
        alu_ctl_o = ALU_SUB;
        ext_op_o = EXT_SIGN;
        npc_sel_o = NPC_BRANCH;
        pc_we = zero_i;
      end
      S_JUMP: begin
        pc_we = 1'b1;
        npc_sel_o = cls == CLS_JR ? NPC_JR : NPC_JUMP;
        reg_we = cls == CLS_JAL;
        reg_dst_o = cls == CLS_JAL ? REG_WRITE_ADDR_R31 : REG_WRITE_ADDR_RD;
        reg_src_o = cls == CLS_JAL ? REG_WRITE_SRC_PC : REG_WRITE_SRC_ALU;
      end
      default: ;
    endcase
  end
  // reset parks the state in FETCH, whose strobes must not fire while rst is held
  assign pc_write_o = pc_we & ~rst;
  assign rgs_ins_write_o = ir_we & ~rst;
  assign reg_write_o = reg_we & ~rst;
  assign mem_write_o = mem_we & ~rst;
  assign state_dbg_o = state_q;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d = state_q inside {S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP} ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign instr_retired_o = cnt_q;
`else
  assign instr_retired_o = '0;
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized self-checking bench for mc_ctrl_fsm against a per-instruction reference model
module tb_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic rst;
  logic [5:0] opcode, funct;
  logic zero, overflow, positive, signed_less;
  logic [1:0] alu_ctl, npc_sel, reg_dst;
  logic [2:0] reg_src;
  logic ext_op, mem_write, mem_op, reg_write, alu_src, rgs_ins_write, pc_write, illegal;
  logic [3:0] state_dbg;
  logic [31:0] instr_retired;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] retired = '0;
  localparam int ADDU = 0, SUBU = 1, SLT = 2, SRA = 3, JR = 4, ORI = 5, LUI = 6, ADDI = 7;
  localparam int LW = 8, LB = 9, SW = 10, SB = 11, BEQ = 12, J = 13, JAL = 14, BAD = 15;
  localparam logic [5:0] OPS [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h08,
                                      6'h23, 6'h20, 6'h2B, 6'h28, 6'h04, 6'h02, 6'h03, 6'h3F};
  localparam logic [5:0] FNS [5] = '{6'h21, 6'h23, 6'h2A, 6'h03, 6'h08};
  always #5 clk = ~clk;
  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
    .overflow_i(overflow), .positive_i(positive), .signed_less_i(signed_less),
    .alu_ctl_o(alu_ctl), .ext_op_o(ext_op), .reg_src_o(reg_src), .npc_sel_o(npc_sel),
    .mem_write_o(mem_write), .mem_op_o(mem_op), .reg_write_o(reg_write), .alu_src_o(alu_src),
    .reg_dst_o(reg_dst), .rgs_ins_write_o(rgs_ins_write), .pc_write_o(pc_write),
    .illegal_o(illegal), .state_dbg_o(state_dbg), .instr_retired_o(instr_retired)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic logic legal_op(input logic [5:0] op);
    return op inside {6'h00, 6'h0D, 6'h0F, 6'h08, 6'h23, 6'h20, 6'h2B, 6'h28, 6'h04, 6'h02, 6'h03};
  endfunction
  function automatic logic legal_fn(input logic [5:0] fn);
    return fn inside {6'h21, 6'h23, 6'h2A, 6'h03, 6'h08};
  endfunction
  // expected state trace, one nibble per cycle, first cycle in the low nibble
  function automatic logic [23:0] seq_of(input int i);
    if (i <= SRA) return 24'h8210;
    if (i == JR || i == J || i == JAL) return 24'hA10;
    if (i <= ADDI) return 24'h8310;
    if (i == LW || i == LB) return 24'h65410;
    if (i == SW || i == SB) return 24'h7410;
    if (i == BEQ) return 24'h910;
    return 24'h10;
  endfunction
  function automatic int len_of(input int i);
    if (i == LW || i == LB) return 5;
    if (i == BEQ || i == J || i == JAL || i == JR) return 3;
    if (i == BAD) return 2;
    return 4;
  endfunction
  function automatic logic [31:0] exp_cnt();
`ifdef MC_CTRL_PERF_CNT_EN
    return retired;
`else
    return 32'd0;
`endif
  endfunction
  task automatic run_instr(input int i, input logic [5:0] bad_op, input int abort);
    logic [23:0] seq;
    logic [3:0] st;
    logic by, ovf_wb;
    seq = seq_of(i);
    opcode = OPS[i];
    funct = 6'($urandom);
    if (i <= JR) funct = FNS[i];
    if (i == BAD) begin
      opcode = bad_op;
      if (bad_op == 6'h00) while (legal_fn(funct)) funct = 6'($urandom);
    end
    by = (i == LB || i == SB);
    for (int k = 0; k < len_of(i); k++) begin
      zero = 1'($urandom);
      overflow = 1'($urandom);
      positive = 1'($urandom);
      signed_less = 1'($urandom);
      #1;
      st = seq[4*k +: 4];
      ovf_wb = st == 4'd8 && i == ADDI && overflow;
      check("state", 32'(state_dbg), 32'(st));
      check("pc_write", 32'(pc_write), 32'(st == 4'd0 || st == 4'd10 || (st == 4'd9 && zero)));
      check("ir_write", 32'(rgs_ins_write), 32'(st == 4'd0));
      check("reg_write", 32'(reg_write), 32'(st == 4'd6 || st == 4'd8 || (st == 4'd10 && i == JAL)));
      check("mem_write", 32'(mem_write), 32'(st == 4'd7));
      check("illegal", 32'(illegal), 32'(st == 4'd1 && i == BAD));
      check("mem_op", 32'(mem_op), 32'((st inside {4'd5, 4'd6, 4'd7}) && by));
      check("npc_sel", 32'(npc_sel), st == 4'd9 ? 32'd1 : st == 4'd10 ? (i == JR ? 32'd3 : 32'd2) : 32'd0);
      check("reg_dst", 32'(reg_dst), st == 4'd6 ? 32'd1 : st == 4'd8 ? (i <= SRA ? 32'd0 : ovf_wb ? 32'd2 : 32'd1)
                                     : (st == 4'd10 && i == JAL) ? 32'd3 : 32'd0);
      check("reg_src", 32'(reg_src), st == 4'd6 ? 32'd1 : st == 4'd8 ? (i == SRA ? 32'd5 : ovf_wb ? 32'd3 : 32'd0)
                                     : (st == 4'd10 && i == JAL) ? 32'd4 : 32'd0);
      check("retired", instr_retired, exp_cnt());
      if (st == 4'd2) begin
        check("exr_alu_src", 32'(alu_src), 32'd0);
        if (i != SRA) check("exr_alu_ctl", 32'(alu_ctl), i == SUBU ? 32'd1 : i == SLT ? 32'd3 : 32'd0);
      end
      if (st == 4'd3) begin
        check("exi_alu_src", 32'(alu_src), 32'd1);
        if (i != LUI) check("exi_alu_ctl", 32'(alu_ctl), i == ORI ? 32'd2 : 32'd0);
        if (i != LUI) check("exi_ext", 32'(ext_op), 32'(i == ADDI));
      end
      if (st == 4'd4 || st == 4'd9) begin
        check("addr_alu_src", 32'(alu_src), 32'(st == 4'd4));
        check("addr_alu_ctl", 32'(alu_ctl), 32'(st == 4'd9));
        check("addr_ext", 32'(ext_op), 32'd1);
      end
      if (st inside {4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd10}) begin
        check("idle_alu_src", 32'(alu_src), 32'd0);
        check("idle_ext", 32'(ext_op), 32'd0);
      end
      if (k == abort) begin
        rst = 1'b1;
        retired = '0;
        #1;
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        check("rst_ir_write", 32'(rgs_ins_write), 32'd0);
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_retired", instr_retired, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (i != BAD) retired++;
  endtask
  initial begin
    int i;
    logic [5:0] bop;
    rst = 1'b1;
    opcode = '0;
    funct = '0;
    zero = 1'b0;
    overflow = 1'b0;
    positive = 1'b0;
    signed_less = 1'b0;
    #2;
    check("reset_state", 32'(state_dbg), 32'd0);
    check("reset_pc_write", 32'(pc_write), 32'd0);
    check("reset_ir_write", 32'(rgs_ins_write), 32'd0);
    check("reset_retired", instr_retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_instr(ADDU, 6'h00, -1);
    run_instr(ADDI, 6'h00, -1);
    run_instr(ADDI, 6'h00, -1);
    run_instr(LW, 6'h00, -1);
    run_instr(SB, 6'h00, -1);
    run_instr(BEQ, 6'h00, -1);
    run_instr(BEQ, 6'h00, -1);
    run_instr(JAL, 6'h00, -1);
    run_instr(JR, 6'h00, -1);
    run_instr(BAD, 6'h3F, -1);
    repeat (300) begin
      i = $urandom_range(0, 15);
      bop = 6'h00;
      if (i == BAD && $urandom_range(0, 1) == 1) begin
        bop = 6'($urandom_range(1, 63));
        while (legal_op(bop)) bop = 6'($urandom_range(1, 63));
      end
      run_instr(i, bop, -1);
    end
    run_instr(LW, 6'h00, 3);
    run_instr(ADDU, 6'h00, -1);
    run_instr(SW, 6'h00, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
